// File: rtl/mem_io_ctrl.sv
// Memory/IO access sequencer: decodes MAR, services keyboard/display registers, times array accesses.
// Optional keyboard interrupt (KBSR[14] enable, kbd_int output) enabled by defining MEM_IO_KBD_INT_EN.
module mem_io_ctrl #(
  parameter int unsigned MEM_LATENCY = 3,
  parameter logic [15:0] KBSR_ADDR   = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR   = 16'hFE02,
  parameter logic [15:0] DSR_ADDR    = 16'hFE04,
  parameter logic [15:0] DDR_ADDR    = 16'hFE06
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  output logic        mem_en,
  output logic        mem_we,
  output logic        in_mux_sel,
  output logic [15:0] dev_data,
  output logic        mem_ready,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        kbd_ack,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ack,
  output logic        kbd_int
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  function automatic logic is_dev(input logic [15:0] a);
    return (a == KBSR_ADDR) || (a == KBDR_ADDR) || (a == DSR_ADDR) || (a == DDR_ADDR);
  endfunction

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        kbsr15_q, dsr15_q, disp_valid_q, kbd_ack_q;
  logic [7:0]  kbdr_q, ddr_q;
  logic        kbsr14;
  logic        done, dev_acc, kbdr_rd_clr, ddr_wr, kbd_accept;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (mio_en) begin
        addr_d = mar;
        rw_d   = r_w;
        if (is_dev(mar) || MEM_LATENCY == 1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = LAT_M1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done       = (state_q == S_DONE);
    dev_acc    = is_dev(addr_q);
    mem_en     = !dev_acc && (state_q == S_WAIT || done);
    mem_we     = done && !dev_acc && rw_q;
    in_mux_sel = done && dev_acc;
    mem_ready  = done;
    dev_data   = '0;
    if (done && dev_acc) begin
      if (addr_q == KBSR_ADDR)      dev_data = {kbsr15_q, kbsr14, 14'b0};
      else if (addr_q == KBDR_ADDR) dev_data = {8'b0, kbdr_q};
      else if (addr_q == DSR_ADDR)  dev_data = {dsr15_q, 15'b0};
    end
  end

  // Device side effects commit on the edge leaving DONE; a KBDR read-clear beats a new key.
  assign kbdr_rd_clr = done && !rw_q && (addr_q == KBDR_ADDR);
  assign ddr_wr      = done && rw_q && (addr_q == DDR_ADDR);
  assign kbd_accept  = kbd_valid && !kbsr15_q && !kbdr_rd_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kbsr15_q     <= 1'b0;
      kbdr_q       <= '0;
      kbd_ack_q    <= 1'b0;
      ddr_q        <= '0;
      dsr15_q      <= 1'b1;
      disp_valid_q <= 1'b0;
    end else begin
      kbd_ack_q <= kbd_accept;
      if (kbdr_rd_clr) begin
        kbsr15_q <= 1'b0;
      end else if (kbd_accept) begin
        kbsr15_q <= 1'b1;
        kbdr_q   <= kbd_data;
      end
      if (ddr_wr && dsr15_q) begin
        ddr_q        <= mdr[7:0];
        dsr15_q      <= 1'b0;
        disp_valid_q <= 1'b1;
      end else if (disp_ack && disp_valid_q) begin
        dsr15_q      <= 1'b1;
        disp_valid_q <= 1'b0;
      end
    end
  end

`ifdef MEM_IO_KBD_INT_EN
  logic kbsr14_q, kbd_int_q;
  logic kbsr_wr;
  assign kbsr_wr = done && rw_q && (addr_q == KBSR_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kbsr14_q  <= 1'b0;
      kbd_int_q <= 1'b0;
    end else begin
      if (kbsr_wr) kbsr14_q <= mdr[14];
      kbd_int_q <= kbsr15_q && kbsr14_q;
    end
  end

  assign kbsr14  = kbsr14_q;
  assign kbd_int = kbd_int_q;
`else
  assign kbsr14  = 1'b0;
  assign kbd_int = 1'b0;
`endif

  // Only the low byte of mdr (and bit 14 with the interrupt option) is architecturally used.
  logic unused_mdr;
  assign unused_mdr = ^mdr[15:8];

  assign kbd_ack    = kbd_ack_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = ddr_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed self-checking bench for mem_io_ctrl (MEM_LATENCY = 3); kbd interrupt checks follow MEM_IO_KBD_INT_EN.
module tb_mem_io_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mio_en, r_w;
  logic [15:0] mar, mdr;
  logic        mem_en, mem_we, in_mux_sel, mem_ready;
  logic [15:0] dev_data;
  logic        kbd_valid, kbd_ack, disp_valid, disp_ack, kbd_int;
  logic [7:0]  kbd_data, disp_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] KBSR = 16'hFE00, KBDR = 16'hFE02, DSR = 16'hFE04, DDR = 16'hFE06;

  mem_io_ctrl #(.MEM_LATENCY(3)) dut (
    .clk(clk), .reset(reset), .mio_en(mio_en), .r_w(r_w), .mar(mar), .mdr(mdr),
    .mem_en(mem_en), .mem_we(mem_we), .in_mux_sel(in_mux_sel), .dev_data(dev_data),
    .mem_ready(mem_ready), .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ack(kbd_ack),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ack(disp_ack), .kbd_int(kbd_int)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one access; results are captured in the mem_ready cycle, and the task returns one
  // cycle later (back in IDLE, side effects committed). lat = 0 means mem_ready never came.
  task automatic access(input logic [15:0] a, input logic w, input logic [15:0] d,
                        input bit chg, input logic [15:0] alt_mar,
                        output logic [15:0] rd, output int lat, output int en_cnt,
                        output int we_cnt, output logic mux);
    mar = a; r_w = w; mdr = d; mio_en = 1'b1;
    lat = 0; en_cnt = 0; we_cnt = 0; rd = 'x; mux = 'x;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (chg && i == 1) begin mar = alt_mar; r_w = ~w; end
      en_cnt += int'(mem_en);
      we_cnt += int'(mem_we);
      if (mem_ready) begin
        lat = i; rd = dev_data; mux = in_mux_sel;
        break;
      end
    end
    mio_en = 1'b0;
    tick();
  endtask

  logic [15:0] rd;
  int          lat, en_cnt, we_cnt;
  logic        mux;

  task automatic test_reset();
    reset = 1'b0; mio_en = 1'b0; r_w = 1'b0; mar = '0; mdr = '0;
    kbd_valid = 1'b0; kbd_data = '0; disp_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    n_checks++; if ({mem_en, mem_we, mem_ready, kbd_ack, disp_valid, in_mux_sel, kbd_int} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000000",
        {mem_en, mem_we, mem_ready, kbd_ack, disp_valid, in_mux_sel, kbd_int}); end
    n_checks++; if (dev_data !== 16'h0 || disp_data !== 8'h0) begin
      n_fail++; $display("FAIL reset_data: got dev=%h disp=%h expected 0000/00", dev_data, disp_data); end
    access(DSR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'h8000) begin n_fail++; $display("FAIL reset_dsr_read: got %h expected 8000", rd); end
    n_checks++; if (lat !== 1 || mux !== 1'b1 || en_cnt !== 0) begin
      n_fail++; $display("FAIL dev_latency: got lat=%0d mux=%b en=%0d expected 1/1/0", lat, mux, en_cnt); end
    access(KBSR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL reset_kbsr_read: got %h expected 0000", rd); end
  endtask

  task automatic test_array_read();
    access(16'h3000, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL array_rd_latency: got %0d expected 3", lat); end
    n_checks++; if (en_cnt !== 3 || we_cnt !== 0) begin
      n_fail++; $display("FAIL array_rd_enables: got en=%0d we=%0d expected 3/0", en_cnt, we_cnt); end
    n_checks++; if (mux !== 1'b0 || rd !== 16'h0) begin
      n_fail++; $display("FAIL array_rd_mux: got mux=%b dev=%h expected 0/0000", mux, rd); end
    n_checks++; if (mem_en !== 1'b0 || mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL array_rd_idle: got en=%b rdy=%b expected 0/0", mem_en, mem_ready); end
  endtask

  task automatic test_array_write();
    access(16'h4000, 1'b1, 16'h1234, 1'b1, 16'h5000, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (lat !== 3 || en_cnt !== 3) begin
      n_fail++; $display("FAIL array_wr_timing: got lat=%0d en=%0d expected 3/3", lat, en_cnt); end
    n_checks++; if (we_cnt !== 1) begin n_fail++; $display("FAIL array_wr_we_count: got %0d expected 1", we_cnt); end
    // A mar change onto a device address mid-access must not turn it into a device access.
    access(16'h3000, 1'b0, 16'h0, 1'b1, DDR, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (lat !== 3 || mux !== 1'b0 || we_cnt !== 0) begin
      n_fail++; $display("FAIL array_mar_latch: got lat=%0d mux=%b we=%0d expected 3/0/0", lat, mux, we_cnt); end
  endtask

  task automatic test_keyboard();
    kbd_valid = 1'b1; kbd_data = 8'h41;
    tick();
    n_checks++; if (kbd_ack !== 1'b1) begin n_fail++; $display("FAIL kbd_ack_pulse: got %b expected 1", kbd_ack); end
    kbd_valid = 1'b0;
    tick();
    n_checks++; if (kbd_ack !== 1'b0) begin n_fail++; $display("FAIL kbd_ack_single: got %b expected 0", kbd_ack); end
    access(KBSR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'h8000) begin n_fail++; $display("FAIL kbsr_full: got %h expected 8000", rd); end
    access(KBDR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'h0041) begin n_fail++; $display("FAIL kbdr_read: got %h expected 0041", rd); end
    access(KBSR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL kbsr_cleared: got %h expected 0000", rd); end
    // Fill with 'B', then hold 'C' while full and across the read-clear edge.
    kbd_valid = 1'b1; kbd_data = 8'h42;
    tick();
    kbd_data = 8'h43;
    tick();
    n_checks++; if (kbd_ack !== 1'b0) begin n_fail++; $display("FAIL kbd_full_no_ack: got %b expected 0", kbd_ack); end
    access(KBDR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'h0042 || kbd_ack !== 1'b0) begin
      n_fail++; $display("FAIL kbd_clear_wins: got rd=%h ack=%b expected 0042/0", rd, kbd_ack); end
    tick();
    n_checks++; if (kbd_ack !== 1'b1) begin n_fail++; $display("FAIL kbd_ack_after_clear: got %b expected 1", kbd_ack); end
    kbd_valid = 1'b0;
    access(KBDR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'h0043) begin n_fail++; $display("FAIL kbdr_second_char: got %h expected 0043", rd); end
  endtask

  task automatic test_display();
    access(DDR, 1'b1, 16'h0058, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (lat !== 1 || en_cnt !== 0 || we_cnt !== 0) begin
      n_fail++; $display("FAIL ddr_wr_access: got lat=%0d en=%0d we=%0d expected 1/0/0", lat, en_cnt, we_cnt); end
    n_checks++; if (disp_valid !== 1'b1 || disp_data !== 8'h58) begin
      n_fail++; $display("FAIL ddr_wr_disp: got valid=%b data=%h expected 1/58", disp_valid, disp_data); end
    access(DSR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL dsr_busy: got %h expected 0000", rd); end
    access(DDR, 1'b1, 16'h0059, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (lat !== 1 || disp_data !== 8'h58) begin
      n_fail++; $display("FAIL ddr_drop: got lat=%0d data=%h expected 1/58", lat, disp_data); end
    access(DDR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL ddr_read_zero: got %h expected 0000", rd); end
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL disp_ack_clear: got %b expected 0", disp_valid); end
    access(DSR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'h8000) begin n_fail++; $display("FAIL dsr_ready_again: got %h expected 8000", rd); end
  endtask

  task automatic test_kbd_int();
    access(KBSR, 1'b1, 16'h4000, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    kbd_valid = 1'b1; kbd_data = 8'h41;
    tick();
    kbd_valid = 1'b0;
    tick();
`ifdef MEM_IO_KBD_INT_EN
    n_checks++; if (kbd_int !== 1'b1) begin n_fail++; $display("FAIL kbd_int_set: got %b expected 1", kbd_int); end
    access(KBSR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'hC000) begin n_fail++; $display("FAIL kbsr_ie_read: got %h expected c000", rd); end
    access(KBDR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    tick();
    n_checks++; if (kbd_int !== 1'b0) begin n_fail++; $display("FAIL kbd_int_clear: got %b expected 0", kbd_int); end
`else
    n_checks++; if (kbd_int !== 1'b0) begin n_fail++; $display("FAIL kbd_int_off: got %b expected 0", kbd_int); end
    access(KBSR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'h8000) begin n_fail++; $display("FAIL kbsr_no_ie: got %h expected 8000", rd); end
    access(KBDR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
`endif
  endtask

  task automatic test_reset_abort();
    int rdy_cnt;
    access(DDR, 1'b1, 16'h005A, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    mar = 16'h4000; r_w = 1'b1; mio_en = 1'b1;
    tick();
    tick();
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL abort_in_wait: got en=%b expected 1", mem_en); end
    reset = 1'b0;
    #1;
    n_checks++; if ({mem_en, mem_we, mem_ready, disp_valid} !== 4'b0) begin
      n_fail++; $display("FAIL abort_reset_outputs: got %b expected 0000", {mem_en, mem_we, mem_ready, disp_valid}); end
    mio_en = 1'b0;
    tick();
    reset = 1'b1;
    rdy_cnt = 0;
    repeat (6) begin tick(); rdy_cnt += int'(mem_ready) + int'(mem_en); end
    n_checks++; if (rdy_cnt !== 0) begin n_fail++; $display("FAIL abort_no_ready: got %0d active cycles expected 0", rdy_cnt); end
    access(DSR, 1'b0, 16'h0, 1'b0, 16'h0, rd, lat, en_cnt, we_cnt, mux);
    n_checks++; if (rd !== 16'h8000) begin n_fail++; $display("FAIL abort_dsr_reinit: got %h expected 8000", rd); end
  endtask

  initial begin
    test_reset();
    test_array_read();
    test_array_write();
    test_keyboard();
    test_display();
    test_kbd_int();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_io_ctrl.md
Name: mem_io_ctrl

Overview:
- Memory/IO access sequencer that sits in front of the MAR/MDR memory array.
- Takes an access request from the control unit and decodes the MAR address.
- Services the memory-mapped keyboard and display registers internally; forwards all other addresses to the memory array.
- Drives the memory enables, the MDR input mux select and device read data, and returns a one-cycle ready (R) pulse that the control FSM waits on.

Parameters:
- MEM_LATENCY, 3, cycles from request sample to mem_ready for array accesses; legal range 1..15.
- KBSR_ADDR, 16'hFE00, keyboard status register address.
- KBDR_ADDR, 16'hFE02, keyboard data register address.
- DSR_ADDR, 16'hFE04, display status register address.
- DDR_ADDR, 16'hFE06, display data register address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mio_en  in  1  access request; level, held until mem_ready.
- r_w  in  1  1 = write, 0 = read.
- mar  in  16  access address.
- mdr  in  16  write data for device registers.
- mem_en  out  1  memory array enable.
- mem_we  out  1  memory array write strobe.
- in_mux_sel  out  1  MDR source: 0 = memory array, 1 = dev_data.
- dev_data  out  16  device register read data.
- mem_ready  out  1  access complete, one-cycle pulse.
- kbd_valid  in  1  keyboard character available.
- kbd_data  in  8  keyboard character.
- kbd_ack  out  1  one-cycle pulse: character latched.
- disp_valid  out  1  display character pending.
- disp_data  out  8  display character.
- disp_ack  in  1  display consumed character.
- kbd_int  out  1  keyboard interrupt request.

Behaviour:
- Reset (async, reset=0):
  - FSM = IDLE.
  - mem_en, mem_we, mem_ready, kbd_ack, disp_valid, in_mux_sel, kbd_int = 0.
  - KBSR = 0, KBDR = 0, DDR = 0, DSR[15] = 1.
  - Reset mid-access aborts it: no mem_ready, no side effects.
- FSM states IDLE, WAIT, DONE:
  - IDLE: when mio_en = 1, latch mar and r_w into internal registers; later changes on mar/r_w are ignored until the next IDLE.
  - Device address (one of the four): IDLE -> DONE.
  - Array address: IDLE -> WAIT, counter = MEM_LATENCY-1. If MEM_LATENCY = 1, go directly to DONE.
  - WAIT: decrement counter; at 0, go to DONE.
  - DONE: mem_ready = 1 for exactly one cycle; always -> IDLE.
  - Back-to-back requests therefore have at least one IDLE cycle between them.
- Latency, with the request sampled at edge 0:
  - Device access: mem_ready high in cycle 1.
  - Array access: mem_ready high in cycle MEM_LATENCY.
- Array accesses:
  - mem_en = 1 in WAIT and DONE.
  - mem_we = 1 only in DONE when the latched r_w = 1.
  - in_mux_sel = 0.
- Device accesses:
  - mem_en = 0 and mem_we = 0.
  - in_mux_sel = 1 in DONE; dev_data is valid in DONE and 0 otherwise.
  - Read values:
    - KBSR = {KBSR[15], KBSR[14], 14'b0}
    - KBDR = {8'b0, KBDR}
    - DSR = {DSR[15], 15'b0}
    - DDR = 16'h0000
- Device side effects commit on the edge that leaves DONE:
  - KBDR read clears KBSR[15].
  - DDR write, when DSR[15] = 1: DDR <= mdr[7:0], DSR[15] <= 0, disp_valid <= 1.
  - DDR write when DSR[15] = 0 is dropped, but the access still completes.
  - Writes to KBDR and DSR are ignored.
  - Write to KBSR updates bit 14 only (see Optional Feature).
- Keyboard:
  - When kbd_valid = 1 and KBSR[15] = 0: KBDR <= kbd_data, KBSR[15] <= 1, kbd_ack pulses for one cycle.
  - When KBSR[15] = 1, kbd_valid is not acknowledged; the source holds the character.
  - If a KBDR read-clear and kbd_valid fall on the same edge, the clear wins; the character is accepted on the next edge.
- Display:
  - disp_data = DDR.
  - disp_ack while disp_valid = 1 sets DSR[15] and clears disp_valid on the same edge.
  - disp_ack while disp_valid = 0 is ignored.

Optional Feature:
- Macro: MEM_IO_KBD_INT_EN.
- Defined:
  - KBSR[14] is an interrupt-enable bit, written from mdr[14] on a KBSR write.
  - kbd_int = KBSR[15] & KBSR[14], registered.
- Undefined:
  - KBSR[14] is held at 0 and reads 0.
  - KBSR writes have no effect.
  - kbd_int tied to 0.

Test Plan:
- Reset: release reset -> all outputs 0 except internal DSR[15]; a DSR read returns 16'h8000, a KBSR read returns 16'h0000.
- Array read, MEM_LATENCY = 3, mar = 16'h3000, r_w = 0 -> mem_en high in cycles 1-3, mem_ready only in cycle 3, in_mux_sel = 0, mem_we never high.
- Array write, mar = 16'h4000, r_w = 1 -> mem_we high only in the mem_ready cycle. A mar change to 16'h5000 during WAIT does not alter the decode.
- Keyboard: kbd_valid with kbd_data = 8'h41 -> kbd_ack pulse; KBSR read returns 16'h8000; KBDR read returns 16'h0041, then KBSR reads 16'h0000. A second char held during the clear edge is acked one cycle later.
- Display: write DDR with mdr = 16'h0058 -> disp_valid = 1, disp_data = 8'h58, DSR reads 16'h0000. A second DDR write with 16'h0059 is dropped. disp_ack -> DSR reads 16'h8000.
- Feature on: write KBSR with 16'h4000, then a key arrives -> kbd_int = 1; KBDR read -> kbd_int = 0. Feature off -> kbd_int stays 0 and KBSR reads 16'h8000.
